// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences instruction-memory requests, tracks wait timeouts,
// and holds branch redirects that resolve while the fetch stage cannot advance.
module fetch_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trigger,
   input  logic                  halt_i,
   input  logic                  StallF_i,
   input  logic                  PCSrcE_i,
   input  logic [DATA_WIDTH-1:0] PCTargetE_i,
   input  logic                  imem_ready_i,
   output logic                  imem_req_o,
   output logic                  PC_en_o,
   output logic                  PCSrc_o,
   output logic [DATA_WIDTH-1:0] PCTarget_o,
   output logic                  FlushD_o,
   output logic                  InstrValid_o,
   output logic                  halted_o,
   output logic                  fault_o,
   output logic [31:0]           InstrCount_o
);

   typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [DATA_WIDTH-1:0] pend_target_q, pend_target_d;
   logic [31:0]           count_q, count_d;
   logic                  fault_q, fault_d;
   logic                  fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         count_q       <= '0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         count_q       <= count_d;
         fault_q       <= fault_d;
      end
   end

   // Redirect outputs are only meaningful while fetching; IDLE and HALT ignore Execute.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      count_d       = count_q;
      fault_d       = fault_q;
      fire          = 1'b0;
      imem_req_o    = 1'b0;
      PC_en_o       = 1'b0;
      PCSrc_o       = 1'b0;
      PCTarget_o    = '0;
      FlushD_o      = 1'b0;
      InstrValid_o  = 1'b0;
      halted_o      = 1'b0;

      case (state_q)
         IDLE: begin
            if (trigger) state_d = RUN;
         end
         HALT: begin
            halted_o = 1'b1;
            if (trigger && !halt_i) begin
               state_d      = RUN;
               fault_d      = 1'b0;
               pend_valid_d = 1'b0;
            end
         end
         RUN, WAIT: begin
            fire         = imem_ready_i & ~StallF_i;
            imem_req_o   = 1'b1;
            PC_en_o      = fire;
            FlushD_o     = PCSrcE_i;
            PCSrc_o      = PCSrcE_i | pend_valid_q;
            PCTarget_o   = PCSrcE_i ? PCTargetE_i : pend_target_q;
            InstrValid_o = fire & ~PCSrcE_i & ~pend_valid_q;

            // A redirect is consumed by the fetch that fires with it; otherwise it is held.
            if (fire) begin
               count_d      = count_q + 32'd1;
               pend_valid_d = 1'b0;
            end else if (PCSrcE_i) begin
               pend_valid_d  = 1'b1;
               pend_target_d = PCTargetE_i;
            end

            if (state_q == RUN) begin
               if (!imem_ready_i) begin
                  state_d    = WAIT;
                  wait_cnt_d = '0;
               end
            end else if (imem_ready_i) begin
               state_d = RUN;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = HALT;
               fault_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end

            if (halt_i) state_d = HALT;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fault_o      = fault_q;
   assign InstrCount_o = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: expected output values are queued with each
// stimulus cycle and compared against the DUT once that cycle has settled.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger, halt_i, StallF_i, PCSrcE_i, imem_ready_i;
   logic [31:0] PCTargetE_i;
   logic        imem_req_o, PC_en_o, PCSrc_o, FlushD_o, InstrValid_o, halted_o, fault_o;
   logic [31:0] PCTarget_o, InstrCount_o;

   typedef enum int {S_REQ, S_PCEN, S_PCSRC, S_TGT, S_FLUSH, S_VALID, S_HALTED, S_FAULT, S_COUNT} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [31:0] value;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_count = 0;

   fetch_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .halt_i(halt_i), .StallF_i(StallF_i),
      .PCSrcE_i(PCSrcE_i), .PCTargetE_i(PCTargetE_i), .imem_ready_i(imem_ready_i),
      .imem_req_o(imem_req_o), .PC_en_o(PC_en_o), .PCSrc_o(PCSrc_o), .PCTarget_o(PCTarget_o),
      .FlushD_o(FlushD_o), .InstrValid_o(InstrValid_o), .halted_o(halted_o), .fault_o(fault_o),
      .InstrCount_o(InstrCount_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] observe(sel_t sel);
      case (sel)
         S_REQ:    return {31'd0, imem_req_o};
         S_PCEN:   return {31'd0, PC_en_o};
         S_PCSRC:  return {31'd0, PCSrc_o};
         S_TGT:    return PCTarget_o;
         S_FLUSH:  return {31'd0, FlushD_o};
         S_VALID:  return {31'd0, InstrValid_o};
         S_HALTED: return {31'd0, halted_o};
         S_FAULT:  return {31'd0, fault_o};
         default:  return InstrCount_o;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic trig, input logic halt, input logic stall,
                                input logic pcsrc, input logic [31:0] tgt, input logic ready);
      trigger      = trig;
      halt_i       = halt;
      StallF_i     = stall;
      PCSrcE_i     = pcsrc;
      PCTargetE_i  = tgt;
      imem_ready_i = ready;
   endtask

   task automatic expectVal(input string tag, input sel_t sel, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.sel   = sel;
      e.value = value;
      sb.push_back(e);
   endtask

   // Inputs are driven 1ns after a rising edge; checks happen 2ns later, before the next edge.
   task automatic step();
      exp_t e;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput(e.tag, observe(e.sel), e.value);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);
      #1;
      expectVal("rst_req", S_REQ, 0);
      expectVal("rst_pcen", S_PCEN, 0);
      expectVal("rst_halted", S_HALTED, 0);
      expectVal("rst_fault", S_FAULT, 0);
      expectVal("rst_count", S_COUNT, 0);
      expectVal("rst_pcsrc", S_PCSRC, 0);
      step();
      rst = 1'b0;

      // Trigger from IDLE, then five back-to-back fetches
      applyStimulus(1, 0, 0, 0, 32'h0, 0);
      expectVal("idle_req", S_REQ, 0);
      expectVal("idle_pcen", S_PCEN, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0, 1);
         expectVal("run_pcen", S_PCEN, 1);
         expectVal("run_valid", S_VALID, 1);
         expectVal("run_count", S_COUNT, exp_count);
         step();
         exp_count++;
      end

      // Short memory wait that recovers before timing out
      applyStimulus(0, 0, 0, 0, 32'h0, 0);
      expectVal("count_after5", S_COUNT, exp_count);
      expectVal("nordy_pcen", S_PCEN, 0);
      expectVal("nordy_req", S_REQ, 1);
      step();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0, 0);
         expectVal("wait_pcen", S_PCEN, 0);
         expectVal("wait_req", S_REQ, 1);
         expectVal("wait_fault", S_FAULT, 0);
         step();
      end
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      expectVal("wait_fire_pcen", S_PCEN, 1);
      expectVal("wait_fire_valid", S_VALID, 1);
      step();
      exp_count++;

      // Memory never ready: four WAIT cycles then HALT with fault
      applyStimulus(0, 0, 0, 0, 32'h0, 0);
      expectVal("recover_count", S_COUNT, exp_count);
      expectVal("recover_fault", S_FAULT, 0);
      expectVal("recover_halted", S_HALTED, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0, 0);
         expectVal("to_wait_req", S_REQ, 1);
         expectVal("to_wait_halted", S_HALTED, 0);
         step();
      end
      applyStimulus(1, 1, 0, 0, 32'h0, 0);
      expectVal("to_halted", S_HALTED, 1);
      expectVal("to_fault", S_FAULT, 1);
      expectVal("to_req", S_REQ, 0);
      step();
      applyStimulus(1, 0, 0, 0, 32'h0, 0);
      expectVal("halt_wins", S_HALTED, 1);
      expectVal("halt_fault_kept", S_FAULT, 1);
      step();

      // Redirect while stalled, carried as pending to the first fire
      applyStimulus(0, 0, 1, 1, 32'h100, 1);
      expectVal("retrig_fault", S_FAULT, 0);
      expectVal("retrig_halted", S_HALTED, 0);
      expectVal("stall_flush", S_FLUSH, 1);
      expectVal("stall_valid", S_VALID, 0);
      expectVal("stall_pcen", S_PCEN, 0);
      expectVal("stall_pcsrc", S_PCSRC, 1);
      expectVal("stall_tgt", S_TGT, 32'h100);
      step();
      applyStimulus(0, 0, 1, 0, 32'h0, 1);
      expectVal("pend_flush", S_FLUSH, 0);
      expectVal("pend_pcsrc", S_PCSRC, 1);
      expectVal("pend_tgt", S_TGT, 32'h100);
      expectVal("pend_valid", S_VALID, 0);
      step();
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      expectVal("pend_fire_pcen", S_PCEN, 1);
      expectVal("pend_fire_pcsrc", S_PCSRC, 1);
      expectVal("pend_fire_tgt", S_TGT, 32'h100);
      expectVal("pend_fire_valid", S_VALID, 0);
      step();
      exp_count++;
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      expectVal("pend_clr_pcsrc", S_PCSRC, 0);
      expectVal("pend_clr_valid", S_VALID, 1);
      expectVal("pend_clr_count", S_COUNT, exp_count);
      step();
      exp_count++;

      // Newer redirect overwrites the pending one during WAIT
      applyStimulus(0, 0, 0, 1, 32'h100, 0);
      expectVal("ovr_flush", S_FLUSH, 1);
      expectVal("ovr_pcen", S_PCEN, 0);
      step();
      applyStimulus(0, 0, 0, 1, 32'h200, 0);
      expectVal("ovr_live_pcsrc", S_PCSRC, 1);
      expectVal("ovr_live_tgt", S_TGT, 32'h200);
      step();
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      expectVal("ovr_fire_pcsrc", S_PCSRC, 1);
      expectVal("ovr_fire_tgt", S_TGT, 32'h200);
      expectVal("ovr_fire_pcen", S_PCEN, 1);
      expectVal("ovr_fire_flush", S_FLUSH, 0);
      step();
      exp_count++;
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      expectVal("ovr_done_pcsrc", S_PCSRC, 0);
      expectVal("ovr_done_count", S_COUNT, exp_count);
      step();
      exp_count++;

      // Reset in WAIT with a pending redirect
      applyStimulus(0, 0, 0, 1, 32'h300, 0);
      expectVal("prerst_flush", S_FLUSH, 1);
      step();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 32'h0, 0);
      expectVal("rstw_req", S_REQ, 1);
      expectVal("rstw_pcsrc", S_PCSRC, 1);
      expectVal("rstw_tgt", S_TGT, 32'h300);
      step();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 1, 32'h400, 0);
      expectVal("postrst_req", S_REQ, 0);
      expectVal("postrst_pcsrc", S_PCSRC, 0);
      expectVal("postrst_flush", S_FLUSH, 0);
      expectVal("postrst_count", S_COUNT, 0);
      expectVal("postrst_pcen", S_PCEN, 0);
      step();
      exp_count = 0;

      // halt_i together with a fire: the fetch still counts
      applyStimulus(1, 0, 0, 0, 32'h0, 0);
      step();
      applyStimulus(0, 1, 0, 0, 32'h0, 1);
      expectVal("haltfire_pcen", S_PCEN, 1);
      expectVal("haltfire_count", S_COUNT, exp_count);
      step();
      exp_count++;
      applyStimulus(0, 0, 0, 1, 32'h500, 1);
      expectVal("halt_halted", S_HALTED, 1);
      expectVal("halt_count", S_COUNT, exp_count);
      expectVal("halt_req", S_REQ, 0);
      expectVal("halt_pcen", S_PCEN, 0);
      expectVal("halt_flush", S_FLUSH, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, PC/target width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max consecutive instruction-memory wait cycles before fault.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port trigger  input  1  start/restart fetching.
REQ-006 SHALL have port halt_i  input  1  stop fetching (ecall/ebreak decoded).
REQ-007 SHALL have port StallF_i  input  1  fetch stall from hazard unit.
REQ-008 SHALL have port PCSrcE_i  input  1  taken branch/jump resolved in Execute.
REQ-009 SHALL have port PCTargetE_i  input  DATA_WIDTH  redirect target from Execute.
REQ-010 SHALL have port imem_ready_i  input  1  instruction memory data valid this cycle.
REQ-011 SHALL have port imem_req_o  output  1  instruction memory read request.
REQ-012 SHALL have port PC_en_o  output  1  PC register enable (drives fetch en).
REQ-013 SHALL have port PCSrc_o  output  1  PC mux select to fetch.
REQ-014 SHALL have port PCTarget_o  output  DATA_WIDTH  PC redirect target to fetch.
REQ-015 SHALL have port FlushD_o  output  1  flush Fetch/Decode register.
REQ-016 SHALL have port InstrValid_o  output  1  fetched instruction valid into Decode.
REQ-017 SHALL have ports halted_o, fault_o  output  1 each  controller stopped; timeout fault.
REQ-018 SHALL have port InstrCount_o  output  32  retired-fetch count.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, WAIT, HALT.
REQ-020 IDLE: imem_req_o=0, PC_en_o=0; trigger=1 -> RUN next cycle.
REQ-021 RUN/WAIT: imem_req_o=1; "fire" = imem_ready_i & ~StallF_i; fire -> PC_en_o=1, InstrValid_o=1, InstrCount_o+1 next cycle (wraps 2^32-1 -> 0).
REQ-022 RUN & ~imem_ready_i -> WAIT; WAIT & imem_ready_i -> RUN; StallF_i alone does not change state.
REQ-023 Wait counter: reset to 0 on entering WAIT, +1 each WAIT cycle without ready; reaching TIMEOUT -> HALT with fault_o=1.
REQ-024 Redirect: PCSrcE_i=1 in RUN/WAIT -> FlushD_o=1 same cycle (combinational), regardless of stall/ready.
REQ-025 Pending redirect register (valid+target): set when PCSrcE_i=1 and not fire; cleared on fire; newer PCSrcE_i overwrites older pending.
REQ-026 PCSrc_o = PCSrcE_i | pend_valid; PCTarget_o = PCSrcE_i ? PCTargetE_i : pend_target; live redirect wins over pending.
REQ-027 InstrValid_o=0 whenever FlushD_o=1 or pending redirect valid (wrong-path instruction).
REQ-028 halt_i=1 in RUN/WAIT -> HALT next cycle; fire in same cycle still completes and counts.
REQ-029 HALT: imem_req_o=0, PC_en_o=0, halted_o=1; trigger=1 -> RUN, fault_o cleared, pending cleared.
REQ-030 In IDLE/HALT PCSrcE_i ignored: FlushD_o=0, pending unchanged-cleared.
REQ-031 halt_i and trigger same cycle in HALT: halt wins (stay HALT).

Reset
REQ-032 rst=1 -> state IDLE, pending cleared, wait counter 0, InstrCount_o=0, all outputs 0 next cycle, overriding any event incl. mid-WAIT or mid-redirect.

Verification
REQ-033 Reset, trigger pulse, imem_ready_i=1 for 5 cycles -> PC_en_o=1 5 cycles, InstrCount_o=5.
REQ-034 RUN, imem_ready_i=0 for 3 cycles then 1 -> WAIT 3 cycles, PC_en_o=0 during, one fire on return, no fault.
REQ-035 ready held 0 with TIMEOUT=4 -> HALT, fault_o=1, halted_o=1 after 4 WAIT cycles; trigger -> RUN, fault_o=0.
REQ-036 PCSrcE_i=1 target 0x100 during StallF_i=1 -> FlushD_o=1, InstrValid_o=0; on first fire PCSrc_o=1, PCTarget_o=0x100, pending cleared.
REQ-037 Pending 0x100 then new PCSrcE_i target 0x200 in WAIT -> fire uses 0x200.
REQ-038 rst=1 during WAIT with pending redirect -> IDLE, count 0, PCSrc_o=0, no request.
